// File: rtl/spi_master_shifter.sv
// SPI master data path: accepts a TX word, shifts MOSI / samples MISO on SCK generator strobes.
// Define SPI_LSB_FIRST_EN for LSB-first framing; the default build is MSB-first.
module spi_master_shifter #(
    parameter int unsigned SPI_MAX_WIDTH_LOG = 4,
    parameter int unsigned DATA_WIDTH        = 2 ** SPI_MAX_WIDTH_LOG
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    input  logic [DATA_WIDTH-1:0]        tx_data,
    input  logic [SPI_MAX_WIDTH_LOG-1:0] spi_width,
    input  logic                         cpha,
    output logic                         spi_start,
    input  logic                         sck_first_edge,
    input  logic                         sck_second_edge,
    input  logic                         spi_finish,
    input  logic                         miso,
    output logic                         mosi,
    output logic                         rx_valid,
    output logic [DATA_WIDTH-1:0]        rx_data,
    output logic                         busy
);
    localparam int unsigned CW = SPI_MAX_WIDTH_LOG + 1;

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e                       state;
    logic                         cpha_q;
    logic [SPI_MAX_WIDTH_LOG-1:0] width_q;
    logic [DATA_WIDTH-1:0]        tx_shift;
    logic [DATA_WIDTH-1:0]        rx_shift;
    logic [DATA_WIDTH-1:0]        rx_shift_nxt;
    logic [DATA_WIDTH-1:0]        rx_mask;
    logic [CW-1:0]                bit_cnt;
    logic [CW-1:0]                n_bits;
    logic [SPI_MAX_WIDTH_LOG-1:0] pad_in;
    logic                         sample_stb;
    logic                         shift_stb;
    logic                         do_sample;

    assign tx_ready = (state == StIdle);
    assign busy     = (state != StIdle);

    // Number of unused bit positions above the frame, for the offered and the latched width
    assign pad_in  = SPI_MAX_WIDTH_LOG'(DATA_WIDTH - 1) - spi_width;
    assign rx_mask = {DATA_WIDTH{1'b1}} >> (SPI_MAX_WIDTH_LOG'(DATA_WIDTH - 1) - width_q);
    assign n_bits  = {1'b0, width_q} + CW'(1);

`ifdef SPI_LSB_FIRST_EN
    assign mosi = (state == StXfer) ? tx_shift[0] : 1'b0;
`else
    assign mosi = (state == StXfer) ? tx_shift[DATA_WIDTH-1] : 1'b0;
`endif

    always_comb begin
        sample_stb   = cpha_q ? sck_second_edge : sck_first_edge;
        shift_stb    = cpha_q ? sck_first_edge : sck_second_edge;
        do_sample    = (state == StXfer) && sample_stb && (bit_cnt < n_bits);
        rx_shift_nxt = rx_shift;
        if (do_sample) begin
`ifdef SPI_LSB_FIRST_EN
            rx_shift_nxt[bit_cnt[SPI_MAX_WIDTH_LOG-1:0]] = miso;
`else
            rx_shift_nxt = {rx_shift[DATA_WIDTH-2:0], miso};
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            cpha_q    <= 1'b0;
            width_q   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            spi_start <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
        end else begin
            spi_start <= 1'b0;
            rx_valid  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (tx_valid) begin
                        cpha_q    <= cpha;
                        width_q   <= spi_width;
`ifdef SPI_LSB_FIRST_EN
                        tx_shift  <= tx_data;
`else
                        tx_shift  <= tx_data << pad_in;
`endif
                        rx_shift  <= '0;
                        bit_cnt   <= '0;
                        spi_start <= 1'b1;
                        state     <= StXfer;
                    end
                end
                StXfer: begin
                    rx_shift <= rx_shift_nxt;
                    if (do_sample) begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                    if (shift_stb) begin
`ifdef SPI_LSB_FIRST_EN
                        tx_shift <= tx_shift >> 1;
`else
                        tx_shift <= tx_shift << 1;
`endif
                    end
                    // A sample landing in the finish cycle is still part of the frame
                    if (spi_finish) begin
                        rx_valid <= 1'b1;
                        rx_data  <= rx_shift_nxt & rx_mask;
                        state    <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Directed self-checking bench for spi_master_shifter; the SCK generator strobes are driven
// by bench tasks. Expectations follow SPI_LSB_FIRST_EN when it is defined.
module tb_spi_master_shifter;
    logic        clk;
    logic        rst_n;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] tx_data;
    logic [3:0]  spi_width;
    logic        cpha;
    logic        spi_start;
    logic        sck_first_edge;
    logic        sck_second_edge;
    logic        spi_finish;
    logic        miso;
    logic        mosi;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        busy;

    logic        loopback;
    logic        miso_fix;
    int          n_assert;
    int          n_fail;
    int          n_start;
    int          n_rxv;
    logic [15:0] ms;

    assign miso = loopback ? mosi : miso_fix;

    spi_master_shifter #(
        .SPI_MAX_WIDTH_LOG(4),
        .DATA_WIDTH       (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .spi_width      (spi_width),
        .cpha           (cpha),
        .spi_start      (spi_start),
        .sck_first_edge (sck_first_edge),
        .sck_second_edge(sck_second_edge),
        .spi_finish     (spi_finish),
        .miso           (miso),
        .mosi           (mosi),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (spi_start) n_start++;
        if (rx_valid) n_rxv++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_first();
        sck_first_edge = 1'b1;
        @(negedge clk);
        sck_first_edge = 1'b0;
        idle(2);
    endtask

    task automatic pulse_second();
        sck_second_edge = 1'b1;
        @(negedge clk);
        sck_second_edge = 1'b0;
        idle(2);
    endtask

    // Generator stand-in: n sample strobes (first leading edge suppressed for cpha=1), then finish.
    // Records mosi at each sample strobe, first bit ending up most significant.
    task automatic gen(input logic cp, input int n, output logic [15:0] stream);
        stream = '0;
        for (int i = 0; i < n; i++) begin
            if (!cp) begin
                stream = {stream[14:0], mosi};
                pulse_first();
                pulse_second();
            end else begin
                if (i > 0) pulse_first();
                stream = {stream[14:0], mosi};
                pulse_second();
            end
        end
        spi_finish = 1'b1;
        @(negedge clk);
        spi_finish = 1'b0;
    endtask

    task automatic accept(input string tag, input logic cp, input logic [3:0] w,
                          input logic [15:0] d);
        tx_data   = d;
        spi_width = w;
        cpha      = cp;
        tx_valid  = 1'b1;
        @(negedge clk);
        tx_valid  = 1'b0;
        chk({tag, ".start"}, 32'(spi_start), 32'd1);
    endtask

    task automatic done_chk(input string tag, input logic [15:0] exp_rx);
        chk({tag, ".rx_valid"}, 32'(rx_valid), 32'd1);
        chk({tag, ".rx_data"}, 32'(rx_data), 32'(exp_rx));
        @(negedge clk);
        chk({tag, ".rx_valid_drop"}, 32'(rx_valid), 32'd0);
        chk({tag, ".tx_ready"}, 32'(tx_ready), 32'd1);
    endtask

    task automatic xfer(input string tag, input logic cp, input logic [3:0] w,
                        input logic [15:0] d, input logic [15:0] exp_rx,
                        output logic [15:0] stream);
        int s0;
        int r0;
        s0 = n_start;
        r0 = n_rxv;
        accept(tag, cp, w, d);
        gen(cp, int'(w) + 1, stream);
        done_chk(tag, exp_rx);
        chk({tag, ".n_start"}, 32'(n_start - s0), 32'd1);
        chk({tag, ".n_rx_valid"}, 32'(n_rxv - r0), 32'd1);
    endtask

    initial begin
        int s0;
        int r0;
        n_assert        = 0;
        n_fail          = 0;
        n_start         = 0;
        n_rxv           = 0;
        rst_n           = 1'b0;
        tx_valid        = 1'b0;
        tx_data         = '0;
        spi_width       = '0;
        cpha            = 1'b0;
        sck_first_edge  = 1'b0;
        sck_second_edge = 1'b0;
        spi_finish      = 1'b0;
        loopback        = 1'b1;
        miso_fix        = 1'b0;
        idle(3);
        chk("rst.spi_start", 32'(spi_start), 32'd0);
        chk("rst.mosi", 32'(mosi), 32'd0);
        chk("rst.rx_valid", 32'(rx_valid), 32'd0);
        chk("rst.rx_data", 32'(rx_data), 32'd0);
        chk("rst.tx_ready", 32'(tx_ready), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Strobes and finish in IDLE must do nothing
        r0 = n_rxv;
        pulse_first();
        spi_finish = 1'b1;
        @(negedge clk);
        spi_finish = 1'b0;
        idle(2);
        chk("idle.busy", 32'(busy), 32'd0);
        chk("idle.rx_valid_cnt", 32'(n_rxv - r0), 32'd0);

        // 1. cpha=0, 8 bits, loopback
        xfer("t1", 1'b0, 4'd7, 16'h00A5, 16'h00A5, ms);
        chk("t1.mosi_stream", 32'(ms), 32'h00A5);

        // 2. cpha=1, 8 bits, loopback; mosi 0,0,1,1,1,1,0,0 at sample strobes
        xfer("t2", 1'b1, 4'd7, 16'h003C, 16'h003C, ms);
        chk("t2.mosi_stream", 32'(ms), 32'h003C);

        // 3. 16 bits, miso tied high
        loopback = 1'b0;
        miso_fix = 1'b1;
        xfer("t3", 1'b0, 4'd15, 16'h1234, 16'hFFFF, ms);
`ifdef SPI_LSB_FIRST_EN
        chk("t3.mosi_stream", 32'(ms), 32'h2C48);
`else
        chk("t3.mosi_stream", 32'(ms), 32'h1234);
`endif
        loopback = 1'b1;

        // Boundaries: single-bit frame, and 4-bit frame with junk above spi_width
        xfer("w0", 1'b0, 4'd0, 16'h0001, 16'h0001, ms);
        xfer("w3", 1'b1, 4'd3, 16'hFFF6, 16'h0006, ms);

        // 4. Second word offered during XFER with different settings
        s0 = n_start;
        accept("t4a", 1'b0, 4'd7, 16'h005A);
        tx_data   = 16'h00C3;
        spi_width = 4'd7;
        cpha      = 1'b1;
        tx_valid  = 1'b1;
        idle(2);
        chk("t4.tx_ready_busy", 32'(tx_ready), 32'd0);
        gen(1'b0, 8, ms);
        chk("t4.n_start_frame1", 32'(n_start - s0), 32'd1);
        done_chk("t4a", 16'h005A);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("t4b.start", 32'(spi_start), 32'd1);
        gen(1'b1, 8, ms);
        done_chk("t4b", 16'h00C3);

        // 5. Reset after 3 samples
        r0 = n_rxv;
        accept("t5", 1'b0, 4'd7, 16'h00FF);
        for (int i = 0; i < 3; i++) begin
            pulse_first();
            pulse_second();
        end
        rst_n = 1'b0;
        #1;
        chk("t5.busy", 32'(busy), 32'd0);
        chk("t5.mosi", 32'(mosi), 32'd0);
        chk("t5.tx_ready", 32'(tx_ready), 32'd1);
        pulse_first();
        spi_finish = 1'b1;
        @(negedge clk);
        spi_finish = 1'b0;
        rst_n = 1'b1;
        idle(3);
        chk("t5.rx_valid_cnt", 32'(n_rxv - r0), 32'd0);
        chk("t5.rx_data", 32'(rx_data), 32'd0);
        xfer("t5b", 1'b0, 4'd7, 16'h0081, 16'h0081, ms);

        // 6. First mosi bit of 0x0001 with 8-bit frame
        tx_data   = 16'h0001;
        spi_width = 4'd7;
        cpha      = 1'b0;
        tx_valid  = 1'b1;
        @(negedge clk);
        tx_valid  = 1'b0;
`ifdef SPI_LSB_FIRST_EN
        chk("t6.first_mosi", 32'(mosi), 32'd1);
`else
        chk("t6.first_mosi", 32'(mosi), 32'd0);
`endif
        gen(1'b0, 8, ms);
        done_chk("t6", 16'h0001);
        idle(2);
        chk("end.mosi_idle", 32'(mosi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
